rc_ppm_encoder: RTL and testbench

Multi-channel PPM (pulse-position modulation) transmitter for RC servo/ESC/downstream-receiver links. It is the transmit-side counterpart of the RC input pulse timers. Software or the flight controller writes per-channel slot widths in clock ticks. The block emits a continuous framed PPM train: one separator pulse per channel, a trailing separator, then a sync gap padding the frame to a programmed length. Channel values are double-buffered so that every frame is internally consistent.

---
 rtl/rc_ppm_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_rc_ppm_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rc_ppm_encoder.sv
// Multi-channel PPM transmitter: double-buffered channel slots, separator pulses,
// trailing separator and a sync gap that pads each frame to a programmed length.
module rc_ppm_encoder #(
    parameter int          NUM_CH       = 8,
    parameter int          AW           = 3,
    parameter logic [30:0] CH_RESET     = 31'd150000,
    parameter logic [30:0] SYNC_MIN     = 31'd400,
    parameter logic        ACTIVE_LEVEL = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          ch_wr,
    input  logic [AW-1:0] ch_addr,
    input  logic [30:0]   ch_data,
    input  logic [30:0]   sep_ticks,
    input  logic [30:0]   frame_ticks,
    output logic          ppm_out,
    output logic          frame_start,
    output logic          busy,
    output logic          overrun
);

    localparam int          CW    = AW + 1;
    localparam logic [30:0] MAX31 = 31'h7FFF_FFFF;
    localparam logic        IDLE_LEVEL = ~ACTIVE_LEVEL;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SPACE,
        SYNC_GAP
    } state_t;

    function automatic logic [30:0] sat31(input logic [36:0] v);
        return (v > {6'd0, MAX31}) ? MAX31 : v[30:0];
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] ch, ch_n;
    logic [30:0]   cnt, cnt_n;
    logic          latch;
    logic          ppm_n, frame_start_n, busy_n, overrun_n;

    logic [30:0]   live   [NUM_CH];
    logic [31:0]   shadow [NUM_CH];
    logic [30:0]   sep_reg;
    logic [30:0]   gap_reg;
    logic          ovr_reg;

    logic [30:0]   sep_in;
    logic [31:0]   slot_in [NUM_CH];
    logic [36:0]   elapsed;
    logic [36:0]   gap_len;
    logic          ovr_in;
    logic [30:0]   gap_load;
    logic [31:0]   cur_slot;
    logic [30:0]   space_load;

    // Everything a frame needs is derived from the live registers at the latch
    // edge, so the gap length is known before the frame even begins.
    always_comb begin
        sep_in  = (sep_ticks == 31'd0) ? 31'd1 : sep_ticks;
        elapsed = {6'd0, sep_in};
        for (int i = 0; i < NUM_CH; i++) begin
            slot_in[i] = (live[i] > sep_in) ? {1'b0, live[i]} : ({1'b0, sep_in} + 32'd1);
            elapsed    = elapsed + {5'd0, slot_in[i]};
        end
        if (elapsed + {6'd0, SYNC_MIN} <= {6'd0, frame_ticks}) begin
            gap_len = {6'd0, frame_ticks} - elapsed;
            ovr_in  = 1'b0;
        end else begin
            gap_len = {6'd0, SYNC_MIN};
            ovr_in  = 1'b1;
        end
        if (gap_len == 37'd0) begin
            gap_len = 37'd1;
        end
        gap_load = sat31(gap_len - 37'd1);
    end

    always_comb begin
        cur_slot = shadow[0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CW'(i)) begin
                cur_slot = shadow[i];
            end
        end
        space_load = sat31({5'd0, cur_slot} - {6'd0, sep_reg} - 37'd1);
    end

    // Segment counters hold "cycles remaining after this one", so a segment ends
    // when the counter reads zero and the next segment's length-1 is loaded.
    always_comb begin
        state_n       = state;
        ch_n          = ch;
        cnt_n         = (cnt == 31'd0) ? 31'd0 : cnt - 31'd1;
        latch         = 1'b0;
        ppm_n         = ppm_out;
        frame_start_n = 1'b0;
        busy_n        = busy;
        overrun_n     = 1'b0;

        case (state)
            IDLE: begin
                ppm_n  = IDLE_LEVEL;
                busy_n = 1'b0;
                latch  = enable;
            end
            PULSE: begin
                if (cnt == 31'd0) begin
                    ppm_n = IDLE_LEVEL;
                    if (ch < CW'(NUM_CH)) begin
                        state_n = SPACE;
                        cnt_n   = space_load;
                    end else begin
                        state_n   = SYNC_GAP;
                        cnt_n     = gap_reg;
                        overrun_n = ovr_reg;
                    end
                end
            end
            SPACE: begin
                if (cnt == 31'd0) begin
                    state_n = PULSE;
                    ch_n    = ch + CW'(1);
                    cnt_n   = sep_reg - 31'd1;
                    ppm_n   = ACTIVE_LEVEL;
                end
            end
            SYNC_GAP: begin
                if (cnt == 31'd0) begin
                    if (enable) begin
                        latch = 1'b1;
                    end else begin
                        state_n = IDLE;
                        ppm_n   = IDLE_LEVEL;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ppm_n   = IDLE_LEVEL;
                busy_n  = 1'b0;
            end
        endcase

        if (latch) begin
            state_n       = PULSE;
            ch_n          = '0;
            cnt_n         = sep_in - 31'd1;
            ppm_n         = ACTIVE_LEVEL;
            frame_start_n = 1'b1;
            busy_n        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ch          <= '0;
            cnt         <= '0;
            ppm_out     <= IDLE_LEVEL;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            sep_reg     <= 31'd1;
            gap_reg     <= '0;
            ovr_reg     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                live[i]   <= CH_RESET;
                shadow[i] <= '0;
            end
        end else begin
            state       <= state_n;
            ch          <= ch_n;
            cnt         <= cnt_n;
            ppm_out     <= ppm_n;
            frame_start <= frame_start_n;
            busy        <= busy_n;
            overrun     <= overrun_n;
            if (latch) begin
                sep_reg <= sep_in;
                gap_reg <= gap_load;
                ovr_reg <= ovr_in;
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow[i] <= slot_in[i];
                end
            end
            // A write on the latch edge lands here but the shadow above already took the old value.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_wr && ch_addr == AW'(i)) begin
                    live[i] <= ch_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rc_ppm_encoder.sv
// Bench for rc_ppm_encoder: a waveform-level model expands each frame into its
// expected per-cycle output and every cycle is compared against the DUT.
module tb_rc_ppm_encoder;

    localparam int          NUM_CH   = 4;
    localparam int          AW       = 3;
    localparam logic [30:0] CH_RESET = 31'd20;
    localparam logic [30:0] SYNC_MIN = 31'd8;
    localparam logic        ACT      = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          ch_wr;
    logic [AW-1:0] ch_addr;
    logic [30:0]   ch_data;
    logic [30:0]   sep_ticks;
    logic [30:0]   frame_ticks;
    logic          ppm_out;
    logic          frame_start;
    logic          busy;
    logic          overrun;

    rc_ppm_encoder #(
        .NUM_CH       (NUM_CH),
        .AW           (AW),
        .CH_RESET     (CH_RESET),
        .SYNC_MIN     (SYNC_MIN),
        .ACTIVE_LEVEL (ACT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ch_wr       (ch_wr),
        .ch_addr     (ch_addr),
        .ch_data     (ch_data),
        .sep_ticks   (sep_ticks),
        .frame_ticks (frame_ticks),
        .ppm_out     (ppm_out),
        .frame_start (frame_start),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ppm;
        logic fs;
        logic bsy;
        logic ovr;
    } exp_t;

    exp_t   exp_q[$];
    longint m_live [NUM_CH];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     fs_seen = 0;

    // Expand one whole frame into per-cycle expected outputs from the slot rules.
    task automatic build_frame();
        longint sep, elapsed, gap;
        longint slot [NUM_CH];
        bit     ovr;
        sep = (sep_ticks == 0) ? 1 : longint'(sep_ticks);
        elapsed = sep;
        for (int i = 0; i < NUM_CH; i++) begin
            slot[i] = (m_live[i] > sep) ? m_live[i] : sep + 1;
            elapsed += slot[i];
        end
        if (elapsed + longint'(SYNC_MIN) <= longint'(frame_ticks)) begin
            gap = longint'(frame_ticks) - elapsed;
            ovr = 1'b0;
        end else begin
            gap = longint'(SYNC_MIN);
            ovr = 1'b1;
        end
        for (int c = 0; c <= NUM_CH; c++) begin
            for (longint k = 0; k < sep; k++)
                exp_q.push_back('{ppm: ACT, fs: (c == 0 && k == 0), bsy: 1'b1, ovr: 1'b0});
            if (c < NUM_CH)
                for (longint k = 0; k < slot[c] - sep; k++)
                    exp_q.push_back('{ppm: ~ACT, fs: 1'b0, bsy: 1'b1, ovr: 1'b0});
        end
        for (longint k = 0; k < gap; k++)
            exp_q.push_back('{ppm: ~ACT, fs: 1'b0, bsy: 1'b1, ovr: (k == 0) && ovr});
    endtask

    task automatic check_output(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    // One clock: advance the model on the inputs seen at this edge, then compare.
    task automatic tick();
        exp_t e;
        if (reset) begin
            exp_q.delete();
            exp_q.push_back('{ppm: ~ACT, fs: 1'b0, bsy: 1'b0, ovr: 1'b0});
            for (int i = 0; i < NUM_CH; i++) m_live[i] = longint'(CH_RESET);
        end else begin
            if (exp_q.size() == 0) begin
                if (enable) build_frame();
                else exp_q.push_back('{ppm: ~ACT, fs: 1'b0, bsy: 1'b0, ovr: 1'b0});
            end
            if (ch_wr && int'(ch_addr) < NUM_CH) m_live[ch_addr] = longint'(ch_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        if (frame_start === 1'b1) fs_seen++;
        check_output("ppm_out", ppm_out, e.ppm);
        check_output("frame_start", frame_start, e.fs);
        check_output("busy", busy, e.bsy);
        check_output("overrun", overrun, e.ovr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_stimulus(input int addr, input int data);
        ch_wr   = 1'b1;
        ch_addr = AW'(addr);
        ch_data = 31'(data);
        tick();
        ch_wr   = 1'b0;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            ch_wr   = ($urandom_range(0, 19) == 0);
            ch_addr = AW'($urandom_range(0, 7));
            ch_data = 31'($urandom_range(0, 40));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            tick();
        end
        ch_wr = 1'b0;
    endtask

    initial begin
        int fs_before;
        reset = 1'b1; enable = 1'b0; ch_wr = 1'b0; ch_addr = '0; ch_data = '0;
        sep_ticks = 31'd4; frame_ticks = 31'd100;
        run(3);
        reset = 1'b0;

        // Nominal frame: widths 10/12/14/16, gap 44, period 100.
        apply_stimulus(0, 10);
        apply_stimulus(1, 12);
        apply_stimulus(2, 14);
        apply_stimulus(3, 16);
        apply_stimulus(5, 99);
        enable = 1'b1;
        run(130);
        apply_stimulus(1, 20);
        run(170);

        // Overrun: all slots 30 pushes content past frame_ticks - SYNC_MIN.
        for (int i = 0; i < NUM_CH; i++) apply_stimulus(i, 30);
        run(300);

        // Clamp: slot below sep+1 becomes sep+1.
        apply_stimulus(0, 3);
        apply_stimulus(1, 10);
        apply_stimulus(2, 12);
        apply_stimulus(3, 14);
        run(230);

        // Disable mid-frame: current frame completes, no new frame_start.
        run(15);
        enable = 1'b0;
        fs_before = fs_seen;
        run(250);
        checks++;
        assert (fs_seen <= fs_before + 1)
        else begin
            errors++;
            $error("[TB] FAIL no_restart: observed %0d frame starts expected at most %0d", fs_seen, fs_before + 1);
        end

        // Reset mid-frame, then restart with reset channel values.
        enable = 1'b1;
        run(37);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(220);

        // Randomized configurations, writes and enable toggles.
        for (int r = 0; r < 20; r++) begin
            sep_ticks   = 31'($urandom_range(0, 6));
            frame_ticks = 31'($urandom_range(40, 220));
            run_random(300);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
